// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 EEPROM-style responder (WREN/WRDI/RDSR/READ/WRITE) backed by an
// internal byte memory. SCK/CS/MOSI are oversampled on ACLK.
module spi_eeprom_responder #(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [7:0]  MEM_INIT = 8'h00
) (
    input  logic ACLK,
    input  logic ARESETn,
    input  logic SPI_SCK,
    input  logic SPI_CS,
    input  logic SPI_MOSI,
    output logic SPI_MISO,
    output logic MISO_OE,
    output logic WEL,
    output logic BUSY
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_STATUS,
        ST_IGNORE
    } state_t;

    state_t state, state_nx;

    logic sck_s1, sck_s2, sck_d;
    logic cs_s1, cs_s2, cs_d;
    logic mosi_s1, mosi_s2;

    logic              cs_assert, cs_deassert;
    logic              sck_rise, sck_fall, byte_done;
    logic [6:0]        rx_sr;
    logic [7:0]        rx_byte;
    logic [2:0]        bit_cnt;
    logic [7:0]        addr_hi;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        tx_sr;
    logic              load_pend;
    logic              wr_pend;
    logic [7:0]        wr_data;
    logic              is_write;
    logic              wel_q;
    logic              busy_q;
    logic [7:0]        mem [0:DEPTH-1];

    // CS sync resets to "asserted" so a CS held low across reset produces no
    // assert strobe: the master must re-assert CS to start a command.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_d   <= 1'b0;
            cs_s1   <= 1'b0;
            cs_s2   <= 1'b0;
            cs_d    <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sck_s1  <= SPI_SCK;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            cs_s1   <= SPI_CS;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            mosi_s1 <= SPI_MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    // SCK strobes are gated by CS low, so a coincident deassert always wins.
    assign cs_assert   = ~cs_s2 &  cs_d;
    assign cs_deassert =  cs_s2 & ~cs_d;
    assign sck_rise    =  sck_s2 & ~sck_d & ~cs_s2 & (state != ST_IDLE);
    assign sck_fall    = ~sck_s2 &  sck_d & ~cs_s2 & (state != ST_IDLE);
    assign rx_byte     = {rx_sr, mosi_s2};
    assign byte_done   = sck_rise & (bit_cnt == 3'd7);

    // FSM state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // Next-state: command dispatch on byte boundaries, CS deassert overrides all
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (cs_assert) state_nx = ST_CMD;
            ST_CMD: begin
                if (byte_done) begin
                    case (rx_byte)
                        8'h05:        state_nx = ST_STATUS;
                        8'h03, 8'h02: state_nx = ST_ADDR_HI;
                        default:      state_nx = ST_IGNORE;
                    endcase
                end
            end
            ST_ADDR_HI: if (byte_done) state_nx = ST_ADDR_LO;
            ST_ADDR_LO: if (byte_done) state_nx = is_write ? ST_WR_DATA : ST_RD_DATA;
            default:    state_nx = state;
        endcase
        if (cs_deassert) state_nx = ST_IDLE;
    end

    // Receive shift register and bit counter; partial bytes die with CS
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else if (cs_assert || cs_deassert) begin
            bit_cnt <= '0;
        end else if (sck_rise) begin
            rx_sr   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Command-level flags: write-enable latch, WRITE command marker, busy
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wel_q    <= 1'b0;
            is_write <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (cs_assert)   busy_q <= 1'b1;
            if (cs_deassert) begin
                busy_q   <= 1'b0;
                is_write <= 1'b0;
                if (is_write) wel_q <= 1'b0;
            end else if (state == ST_CMD && byte_done) begin
                is_write <= (rx_byte == 8'h02);
                if (rx_byte == 8'h06) wel_q <= 1'b1;
                if (rx_byte == 8'h04) wel_q <= 1'b0;
            end
        end
    end

    // Address capture and post-increment on each read load or memory write
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            addr_hi <= '0;
            addr    <= '0;
        end else begin
            if (state == ST_ADDR_HI && byte_done) addr_hi <= rx_byte;
            if (state == ST_ADDR_LO && byte_done) begin
                addr <= ADDR_W'({addr_hi, rx_byte});
            end else if (wr_pend) begin
                addr <= addr + 1'b1;
            end else if (sck_fall && load_pend && state == ST_RD_DATA) begin
                addr <= addr + 1'b1;
            end
        end
    end

    // TX path: a completed byte arms a load that happens on the next SCK fall;
    // other falls shift the register left
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            tx_sr     <= '0;
            load_pend <= 1'b0;
        end else if (cs_deassert) begin
            tx_sr     <= '0;
            load_pend <= 1'b0;
        end else begin
            if (byte_done && (state_nx == ST_RD_DATA || state_nx == ST_STATUS))
                load_pend <= 1'b1;
            if (sck_fall) begin
                if (load_pend) begin
                    load_pend <= 1'b0;
                    tx_sr     <= (state == ST_STATUS) ? {6'b0, wel_q, 1'b0} : mem[addr];
                end else begin
                    tx_sr <= {tx_sr[6:0], 1'b0};
                end
            end
        end
    end

    // Write staging: a complete byte received with WEL set is committed next cycle
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_pend <= 1'b0;
            wr_data <= '0;
        end else begin
            wr_pend <= state == ST_WR_DATA && byte_done && wel_q;
            if (state == ST_WR_DATA && byte_done) wr_data <= rx_byte;
        end
    end

    // Backing memory, fully reset to MEM_INIT
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= MEM_INIT;
        end else if (wr_pend) begin
            mem[addr] <= wr_data;
        end
    end

    assign MISO_OE  = (state == ST_RD_DATA || state == ST_STATUS) & ~cs_s2;
    assign SPI_MISO = tx_sr[7] & MISO_OE;
    assign WEL      = wel_q;
    assign BUSY     = busy_q;

endmodule
